ddr2_app_arbiter: RTL
=====================

DDR2_APP_ARBITER -- requirements
Module: ddr2_app_arbiter

Interface
REQ-001 Parameter APPDATA_WIDTH, default 32: MIG user data bus width.
REQ-002 Parameter ADDR_WIDTH, default 31: MIG app_af_addr width.
REQ-003 Parameter RD_MAX, default 8: maximum outstanding read bursts (1..15).
REQ-004 clk  input  1: sole clock (MIG clk0 domain); all logic rising-edge.
REQ-005 reset  input  1: asynchronous, active-high reset.
REQ-006 phy_init_done  input  1: controller calibrated; no command issued while low.
REQ-007 wr_req  input  1; wr_addr  input  ADDR_WIDTH; wr_data0/wr_data1  input  APPDATA_WIDTH each: write-burst request with both beats.
REQ-008 wr_ack  output  1: one-cycle pulse, write burst accepted; requester may change inputs next cycle.
REQ-009 rd_req  input  1; rd_addr  input  ADDR_WIDTH: read-burst request.
REQ-010 rd_ack  output  1: one-cycle pulse, read command issued.
REQ-011 app_af_afull, app_wdf_afull, rd_data_valid  inputs  1 each: MIG status.
REQ-012 app_af_wren  output  1; app_af_addr  output  ADDR_WIDTH; app_af_cmd  output  3: command FIFO write.
REQ-013 app_wdf_wren  output  1; app_wdf_data  output  APPDATA_WIDTH; app_wdf_mask_data  output  APPDATA_WIDTH/8: write data FIFO.
REQ-014 rd_outstanding  output  4: read bursts issued but not fully returned.

Function
REQ-015 FSM states IDLE, WR_BEAT1, WR_BEAT2; read issue completes within IDLE in one cycle.
REQ-016 IDLE grant condition: phy_init_done=1 and app_af_afull=0; write additionally needs app_wdf_afull=0; read additionally needs rd_outstanding<RD_MAX (when limit enabled).
REQ-017 Both requests eligible in same cycle: round-robin; last_grant register selects the opposite requester; last_grant resets to READ (write wins first tie).
REQ-018 Write grant: cycle N app_af_wren=1, cmd=3'b000, addr=wr_addr, app_wdf_wren=1, data=wr_data0, wr_ack=1; state->WR_BEAT2.
REQ-019 WR_BEAT2: app_wdf_wren=1, data=wr_data1 (latched at N), no af write, no grant; state->IDLE. WR_BEAT1 is a one-cycle holding state entered only when app_wdf_afull rises in WR_BEAT2, resuming beat 2 when it clears.
REQ-020 Read grant: app_af_wren=1, cmd=3'b001, addr=rd_addr, rd_ack=1, same cycle; state stays IDLE; back-to-back reads allowed.
REQ-021 app_wdf_mask_data SHALL be all zeros whenever driven.
REQ-022 rd_outstanding +1 on read grant, -1 on every second rd_data_valid beat (beat-parity toggle); simultaneous +1/-1 leaves value unchanged.
REQ-023 rd_outstanding saturates at 15 and 0; decrement at 0 is ignored and beat parity reset.
REQ-024 Outputs registered; command/data outputs valid only with their wren; otherwise held at 0.
REQ-025 Requests dropped before ack are not issued; no request queueing.

Reset
REQ-026 On reset: state IDLE, all wren/ack outputs 0, addr/data/cmd 0, rd_outstanding 0, beat parity 0, last_grant READ.
REQ-027 Reset mid-write (after beat 1) abandons beat 2; requester re-issues after reset.

Configuration
REQ-028 Macro DDR2_ARB_RD_LIMIT_EN defined: RD_MAX gating per REQ-016 applies.
REQ-029 Macro undefined: no read gating; rd_outstanding still counts and saturates.

Structure
REQ-030 Shared package ddr2_arb_pkg holds FSM state encoding, CMD_WRITE=3'b000, CMD_READ=3'b001, grant enum.
REQ-031 Sub-module ddr2_rd_tracker implements REQ-022/023 counter.

Verification
REQ-032 phy_init_done=0, wr_req=1 -> no af/wdf writes; raise phy_init_done -> wr_ack one cycle later, cmd 000.
REQ-033 wr_req, wr_addr=0x40, data0=0xA5A5_0001, data1=0xA5A5_0002 -> af addr 0x40, wdf beats 0xA5A5_0001 then 0xA5A5_0002 consecutive.
REQ-034 wr_req and rd_req held together -> grants alternate W,R,W,R; first W.
REQ-035 RD_MAX=8, macro defined, 10 reads, no rd_data_valid -> exactly 8 rd_ack; 2 valid beats -> one more ack.
REQ-036 app_af_afull=1 with both requests -> no grants; app_wdf_afull high in WR_BEAT2 -> beat 2 delayed until low.
REQ-037 Reset asserted after beat 1 -> outputs 0 asynchronously; rd_outstanding 0.

Source files
------------

// File: rtl/ddr2_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : ddr2_arb_pkg
// Brief  : Shared types and constants for the DDR2 application-side arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package ddr2_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_WR_BEAT1 = 2'd1,
      ST_WR_BEAT2 = 2'd2
   } arb_state_e;

   typedef enum logic {
      GRANT_READ  = 1'b0,
      GRANT_WRITE = 1'b1
   } grant_e;

   localparam logic [2:0] CMD_WRITE    = 3'b000;
   localparam logic [2:0] CMD_READ     = 3'b001;
   localparam int         RD_CNT_WIDTH = 4;
   localparam logic [3:0] RD_CNT_MAX   = 4'hF;

endpackage
`default_nettype wire

// File: rtl/ddr2_app_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : ddr2_app_arbiter_if
// Brief  : Requester handshakes plus MIG user-interface signals of the arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface ddr2_app_arbiter_if #(
   parameter int APPDATA_WIDTH = 32,
   parameter int ADDR_WIDTH    = 31
);
   import ddr2_arb_pkg::*;

   logic                       phy_init_done;
   logic                       wr_req;
   logic [ADDR_WIDTH-1:0]      wr_addr;
   logic [APPDATA_WIDTH-1:0]   wr_data0;
   logic [APPDATA_WIDTH-1:0]   wr_data1;
   logic                       wr_ack;
   logic                       rd_req;
   logic [ADDR_WIDTH-1:0]      rd_addr;
   logic                       rd_ack;
   logic                       app_af_afull;
   logic                       app_wdf_afull;
   logic                       rd_data_valid;
   logic                       app_af_wren;
   logic [ADDR_WIDTH-1:0]      app_af_addr;
   logic [2:0]                 app_af_cmd;
   logic                       app_wdf_wren;
   logic [APPDATA_WIDTH-1:0]   app_wdf_data;
   logic [APPDATA_WIDTH/8-1:0] app_wdf_mask_data;
   logic [RD_CNT_WIDTH-1:0]    rd_outstanding;

   modport master (
      input  phy_init_done, wr_req, wr_addr, wr_data0, wr_data1, rd_req, rd_addr,
             app_af_afull, app_wdf_afull, rd_data_valid,
      output wr_ack, rd_ack, app_af_wren, app_af_addr, app_af_cmd,
             app_wdf_wren, app_wdf_data, app_wdf_mask_data, rd_outstanding
   );

   modport slave (
      output phy_init_done, wr_req, wr_addr, wr_data0, wr_data1, rd_req, rd_addr,
             app_af_afull, app_wdf_afull, rd_data_valid,
      input  wr_ack, rd_ack, app_af_wren, app_af_addr, app_af_cmd,
             app_wdf_wren, app_wdf_data, app_wdf_mask_data, rd_outstanding
   );

endinterface
`default_nettype wire

// File: rtl/ddr2_rd_tracker.sv
`default_nettype none
// ============================================================================
// Module : ddr2_rd_tracker
// Brief  : Counts read bursts in flight; two rd_data_valid beats retire one.
// Rev    : 1.0  initial release
// ============================================================================
module ddr2_rd_tracker
   import ddr2_arb_pkg::*;
(
   input  wire logic                    clk,
   input  wire logic                    reset,
   input  wire logic                    rd_grant,
   input  wire logic                    rd_data_valid,
   output logic [RD_CNT_WIDTH-1:0]      rd_outstanding
);

   logic [RD_CNT_WIDTH-1:0] count_q, count_d;
   logic                    parity_q, parity_d;
   logic                    retire;

   always_comb begin
      count_d  = count_q;
      parity_d = parity_q;
      retire   = 1'b0;
      // A beat with nothing outstanding is stray: drop it and realign parity.
      if (rd_data_valid) begin
         if (count_q == '0) begin
            parity_d = 1'b0;
         end else begin
            retire   = parity_q;
            parity_d = ~parity_q;
         end
      end
      if (rd_grant && !retire && (count_q != RD_CNT_MAX)) begin
         count_d = count_q + 1'b1;
      end else if (retire && !rd_grant) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q  <= '0;
         parity_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         parity_q <= parity_d;
      end
   end

   assign rd_outstanding = count_q;

endmodule
`default_nettype wire

// File: rtl/ddr2_app_arbiter.sv
`default_nettype none
// ============================================================================
// Module : ddr2_app_arbiter
// Brief  : Round-robin write/read arbiter feeding the MIG command and write
//          data FIFOs. Define DDR2_ARB_RD_LIMIT_EN to cap reads in flight.
// Rev    : 1.0  initial release
// ============================================================================
module ddr2_app_arbiter
   import ddr2_arb_pkg::*;
#(
   parameter int APPDATA_WIDTH = 32,
   parameter int ADDR_WIDTH    = 31,
   parameter int RD_MAX        = 8
) (
   input  wire logic          clk,
   input  wire logic          reset,
   ddr2_app_arbiter_if.master bus
);

`ifdef DDR2_ARB_RD_LIMIT_EN
   localparam logic RD_LIMIT_OFF = 1'b0;
`else
   localparam logic RD_LIMIT_OFF = 1'b1;
`endif

   arb_state_e               state_q, state_d;
   grant_e                   last_grant_q, last_grant_d;
   logic [APPDATA_WIDTH-1:0] wr_data1_q, wr_data1_d;
   logic                     af_wren_q, af_wren_d;
   logic [ADDR_WIDTH-1:0]    af_addr_q, af_addr_d;
   logic [2:0]               af_cmd_q, af_cmd_d;
   logic                     wdf_wren_q, wdf_wren_d;
   logic [APPDATA_WIDTH-1:0] wdf_data_q, wdf_data_d;
   logic                     wr_ack_q, wr_ack_d;
   logic                     rd_ack_q, rd_ack_d;
   logic                     rd_grant;
   logic                     rd_room, wr_ok, rd_ok;
   logic [RD_CNT_WIDTH-1:0]  rd_outstanding;

   assign rd_room = RD_LIMIT_OFF || (rd_outstanding < RD_CNT_WIDTH'(RD_MAX));
   assign wr_ok   = bus.phy_init_done && !bus.app_af_afull && !bus.app_wdf_afull && bus.wr_req;
   assign rd_ok   = bus.phy_init_done && !bus.app_af_afull && rd_room && bus.rd_req;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wr_data1_d   = wr_data1_q;
      af_wren_d    = 1'b0;
      af_addr_d    = '0;
      af_cmd_d     = CMD_WRITE;
      wdf_wren_d   = 1'b0;
      wdf_data_d   = '0;
      wr_ack_d     = 1'b0;
      rd_ack_d     = 1'b0;
      rd_grant     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // On a tie the requester that did not win last time goes first.
            if (wr_ok && (!rd_ok || last_grant_q == GRANT_READ)) begin
               af_wren_d    = 1'b1;
               af_addr_d    = bus.wr_addr;
               af_cmd_d     = CMD_WRITE;
               wdf_wren_d   = 1'b1;
               wdf_data_d   = bus.wr_data0;
               wr_ack_d     = 1'b1;
               wr_data1_d   = bus.wr_data1;
               last_grant_d = GRANT_WRITE;
               state_d      = ST_WR_BEAT2;
            end else if (rd_ok) begin
               af_wren_d    = 1'b1;
               af_addr_d    = bus.rd_addr;
               af_cmd_d     = CMD_READ;
               rd_ack_d     = 1'b1;
               rd_grant     = 1'b1;
               last_grant_d = GRANT_READ;
            end
         end
         ST_WR_BEAT2, ST_WR_BEAT1: begin
            if (!bus.app_wdf_afull) begin
               wdf_wren_d = 1'b1;
               wdf_data_d = wr_data1_q;
               state_d    = ST_IDLE;
            end else begin
               state_d    = ST_WR_BEAT1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         last_grant_q <= GRANT_READ;
         wr_data1_q   <= '0;
         af_wren_q    <= 1'b0;
         af_addr_q    <= '0;
         af_cmd_q     <= CMD_WRITE;
         wdf_wren_q   <= 1'b0;
         wdf_data_q   <= '0;
         wr_ack_q     <= 1'b0;
         rd_ack_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wr_data1_q   <= wr_data1_d;
         af_wren_q    <= af_wren_d;
         af_addr_q    <= af_addr_d;
         af_cmd_q     <= af_cmd_d;
         wdf_wren_q   <= wdf_wren_d;
         wdf_data_q   <= wdf_data_d;
         wr_ack_q     <= wr_ack_d;
         rd_ack_q     <= rd_ack_d;
      end
   end

   ddr2_rd_tracker u_rd_tracker (
      .clk            (clk),
      .reset          (reset),
      .rd_grant       (rd_grant),
      .rd_data_valid  (bus.rd_data_valid),
      .rd_outstanding (rd_outstanding)
   );

   assign bus.app_af_wren       = af_wren_q;
   assign bus.app_af_addr       = af_addr_q;
   assign bus.app_af_cmd        = af_cmd_q;
   assign bus.app_wdf_wren      = wdf_wren_q;
   assign bus.app_wdf_data      = wdf_data_q;
   assign bus.app_wdf_mask_data = '0;
   assign bus.wr_ack            = wr_ack_q;
   assign bus.rd_ack            = rd_ack_q;
   assign bus.rd_outstanding    = rd_outstanding;

endmodule
`default_nettype wire
